// File: rtl/bist_pattern_gen_if.sv
// Handshake/bus bundle between the BIST controller and the SRAM pattern sequencer.
interface bist_pattern_gen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic                  cen;
  logic [1:0]            mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  we;
  logic                  re;
  logic [1:0]            phase;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cen, mode,
    input  addr, wdata, exp_data, we, re, phase, busy, done
  );

  modport slave (
    input  start, cen, mode,
    output addr, wdata, exp_data, we, re, phase, busy, done
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// SRAM BIST sequencer: W0, R0, W1, R1 full-array passes with four background patterns.
// Optional macro BIST_DOWN_READ_EN makes the R1 pass walk addresses downwards.
module bist_pattern_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int COL_BITS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  bist_pattern_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_R0   = 3'd2,
    S_W1   = 3'd3,
    S_R1   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] bg;

  // Bit i of the alternating mask is i[0]; it provides the intra-word toggle.
  function automatic logic [DATA_WIDTH-1:0] bg_word(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] alt;
    logic [DATA_WIDTH-1:0] w;
    for (int i = 0; i < DATA_WIDTH; i++) alt[i] = ((i % 2) == 1);
    case (m)
      2'b01:   w = {DATA_WIDTH{a[0] ^ a[COL_BITS]}} ^ alt;
      2'b10:   w = {DATA_WIDTH{a[COL_BITS]}};
      2'b11:   w = {DATA_WIDTH{a[0]}} ^ alt;
      default: w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_W0;
          addr_d  = '0;
          mode_d  = bus.mode;
        end
      end
      S_W0, S_R0, S_W1, S_R1: begin
        if (bus.cen) begin
`ifdef BIST_DOWN_READ_EN
          if (state_q == S_R1) begin
            if (addr_q == '0) state_d = S_DONE;
            else              addr_d  = addr_q - ADDR_WIDTH'(1);
          end else if (addr_q == ADDR_MAX) begin
            // W1 exit preloads the top address so R1 can count down.
            addr_d = (state_q == S_W1) ? ADDR_MAX : '0;
            case (state_q)
              S_W0:    state_d = S_R0;
              S_R0:    state_d = S_W1;
              default: state_d = S_R1;
            endcase
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
`else
          if (addr_q == ADDR_MAX) begin
            addr_d = '0;
            case (state_q)
              S_W0:    state_d = S_R0;
              S_R0:    state_d = S_W1;
              S_W1:    state_d = S_R1;
              default: state_d = S_DONE;
            endcase
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_comb begin
    bg           = bg_word(mode_q, addr_q);
    bus.addr     = addr_q;
    bus.wdata    = '0;
    bus.exp_data = '0;
    bus.we       = 1'b0;
    bus.re       = 1'b0;
    bus.phase    = 2'd0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_W0: begin
        bus.we    = 1'b1;
        bus.wdata = bg;
        bus.busy  = 1'b1;
      end
      S_R0: begin
        bus.re       = 1'b1;
        bus.exp_data = bg;
        bus.phase    = 2'd1;
        bus.busy     = 1'b1;
      end
      S_W1: begin
        bus.we    = 1'b1;
        bus.wdata = ~bg;
        bus.phase = 2'd2;
        bus.busy  = 1'b1;
      end
      S_R1: begin
        bus.re       = 1'b1;
        bus.exp_data = ~bg;
        bus.phase    = 2'd3;
        bus.busy     = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/bist_pattern_gen.md
Name: bist_pattern_gen

Overview:
- Parametrised address/data sequencer for the SRAM BIST engine.
- Runs four full-array passes in order: write background, read background, write inverse, read inverse.
- Drives SRAM address, write data, expected read data and the we/re strobes.
- Supports four selectable background patterns and a `done` flag for the BIST controller/comparator.

Parameters:
- ADDR_WIDTH, 8, SRAM address width; array depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 4, SRAM word width.
- COL_BITS, 2, number of low address bits forming the column index; addr[COL_BITS] is the row LSB. Legal range 1..ADDR_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- cen  input  1  advance enable; 0 freezes all state.
- mode  input  2  pattern: 00 solid, 01 checkerboard, 10 row stripe, 11 column stripe. Latched on accepted start.
- addr  output  ADDR_WIDTH  SRAM address.
- wdata  output  DATA_WIDTH  write data, valid when we=1.
- exp_data  output  DATA_WIDTH  expected read data, valid when re=1.
- we  output  1  write strobe.
- re  output  1  read strobe.
- phase  output  2  current pass: 0 W0, 1 R0, 2 W1, 3 R1.
- busy  output  1  high in W0/R0/W1/R1.
- done  output  1  high in DONE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, W0, R0, W1, R1, DONE.
- Registered state: state, addr counter (ADDR_WIDTH bits), latched mode (2 bits).
- All outputs are combinational decodes of registered state, so there is zero latency from state to outputs.
- Reset (rst=1 at a clock edge) gives state=IDLE, addr=0, latched mode=00.
  - Resulting outputs: we=re=busy=done=0, phase=0, wdata=exp_data=0.
  - rst overrides start and cen, including mid-run.
- IDLE:
  - start=1 → W0, addr=0, latch mode. cen is not required for this transition.
  - Otherwise hold.
- W0/R0/W1/R1, cen=1:
  - If addr != all-ones: addr increments.
  - If addr == all-ones: addr wraps to 0 and state advances W0→R0→W1→R1→DONE.
- W0/R0/W1/R1, cen=0: hold all state and outputs. Strobes remain asserted; the SRAM side qualifies accesses with cen.
- start is ignored while busy.
- DONE:
  - done=1, addr=0, strobes low.
  - start=1 restarts at W0 and latches the new mode.
  - Otherwise hold indefinitely.
- Strobes:
  - we=1 in W0 and W1.
  - re=1 in R0 and R1.
  - phase reflects the current pass (0 in IDLE and DONE).
- Background word bg, bit i, for a = current addr:
  - solid: 0.
  - checkerboard: a[0] ^ a[COL_BITS] ^ i[0].
  - row stripe: a[COL_BITS].
  - column stripe: a[0] ^ i[0].
- Data decode:
  - W0: wdata = bg.
  - R0: exp_data = bg.
  - W1: wdata = ~bg.
  - R1: exp_data = ~bg.
  - Unused data output is 0.
  - Pattern decode uses the latched mode only; changing the mode input mid-run has no effect.
- Run length: exactly 4·2^ADDR_WIDTH cen-qualified cycles from W0 entry to DONE (1024 at defaults).

Optional Feature:
- Macro: BIST_DOWN_READ_EN.
- Defined:
  - R1 traverses addresses descending: entry addr = all-ones, decrement, exit to DONE after addr 0.
  - The last W1 cycle loads addr with all-ones instead of 0.
  - bg is computed from the actual address, so expected data still tracks the address.
- Not defined: all passes ascend as described above.
- Total cycle count is identical in both builds.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then cen=1 with start=0 for 10 cycles → addr=0, we=re=busy=done=0, phase=0 throughout.
- Full solid run, defaults: start with mode=00, cen held 1.
  - W0: we=1, wdata=0000 at addr 0..255.
  - R0: re=1, exp_data=0000.
  - W1: wdata=1111.
  - R1: exp_data=1111.
  - done=1 exactly 1024 cycles after W0 entry.
- Checkerboard decode, mode=01:
  - W0 addr 0 → 1010 (bit0=0).
  - addr 1 → 0101.
  - addr 4 → 0101.
  - addr 5 → 1010.
  - W1 at addr 0 → 0101.
- Stall and boundary:
  - Drop cen for 3 cycles at W0 addr 255 → addr/we/state frozen.
  - On cen=1 → R0, addr=0.
  - A start pulse during busy has no effect.
- Reset mid-run: rst=1 during R0 addr 37 → next cycle IDLE, addr=0, strobes low; a new start with mode=10 begins W0 with wdata=0000 at addr 0 and 1111 at addr 4.
- BIST_DOWN_READ_EN build:
  - R1 first address is 255, last is 0.
  - R1 exp_data at addr 255 under mode=11 is 1010.
  - done asserts after 1024 cycles.
